// File: rtl/line_tracker_filter.sv
// Conditions three raw IR line sensors into a stable 3-bit motor command:
// synchronise, debounce, remap glitch codes, and substitute recovery moves when the line is lost.
module line_tracker_filter #(
   parameter int SYNC_STAGES      = 2,
   parameter int STABLE_CYCLES    = 100000,
   parameter int LOST_HOLD_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left_signal,
   input  logic       mid_signal,
   input  logic       right_signal,
   output logic [2:0] mode,
   output logic       mode_valid,
   output logic       lost
);

   localparam int CNT_W  = $clog2(STABLE_CYCLES);
   localparam int HOLD_W = $clog2(LOST_HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOST_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {TRACK, LOST_HOLD, LOST_SEARCH} state_e;
   typedef enum logic [1:0] {SIDE_NONE, SIDE_LEFT, SIDE_RIGHT} side_e;

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0]                  sync_vec;
   logic [2:0]                  cand_q, cand_d;
   logic [2:0]                  stable_q, stable_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        commit;
   logic [2:0]                  pat, pat_prev_q;
   side_e                       side_q, side_d;
   state_e                      state_q, state_d;
   logic [HOLD_W-1:0]           hold_q, hold_d;
   logic [2:0]                  mode_q, mode_d;
   logic                        mode_valid_q, lost_q;

   assign sync_vec = sync_q[SYNC_STAGES-1];

   // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
   always_comb begin
      commit   = (cand_q != stable_q) && (cnt_q == CNT_LAST);
      stable_d = commit ? cand_q : stable_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      if (sync_vec != cand_q) begin
         cand_d = sync_vec;
         cnt_d  = '0;
      end else if (commit || (cand_q == stable_q)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // 101 is treated as a sensor glitch: the previous command is kept.
   always_comb begin
      case (stable_q)
         3'b010:  pat = 3'b111;
         3'b101:  pat = pat_prev_q;
         default: pat = stable_q;
      endcase
   end

   always_comb begin
      side_d = side_q;
      if (pat != pat_prev_q) begin
         case (pat)
            3'b110, 3'b100: side_d = SIDE_LEFT;
            3'b011, 3'b001: side_d = SIDE_RIGHT;
            3'b111:         side_d = SIDE_NONE;
            default:        side_d = side_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      case (state_q)
         TRACK: begin
            if (pat == 3'b000) state_d = LOST_HOLD;
         end
         LOST_HOLD: begin
            if (pat != 3'b000)           state_d = TRACK;
            else if (hold_q == HOLD_LAST) state_d = LOST_SEARCH;
            else                          hold_d  = hold_q + 1'b1;
         end
         LOST_SEARCH: begin
            if (pat != 3'b000) state_d = TRACK;
         end
         default: state_d = TRACK;
      endcase
   end

   // Outputs are registered from the state being entered, so mode and lost move together.
   always_comb begin
      case (state_d)
         LOST_HOLD: begin
            case (side_q)
               SIDE_LEFT:  mode_d = 3'b100;
               SIDE_RIGHT: mode_d = 3'b001;
               default:    mode_d = 3'b000;
            endcase
         end
         LOST_SEARCH: mode_d = 3'b010;
         default:     mode_d = pat;
      endcase
   end

   // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q       <= {SYNC_STAGES{3'b111}};
         cand_q       <= 3'b111;
         stable_q     <= 3'b111;
         cnt_q        <= '0;
         pat_prev_q   <= 3'b111;
         side_q       <= SIDE_NONE;
         state_q      <= TRACK;
         hold_q       <= '0;
         mode_q       <= 3'b111;
         mode_valid_q <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], {left_signal, mid_signal, right_signal}};
         cand_q       <= cand_d;
         stable_q     <= stable_d;
         cnt_q        <= cnt_d;
         pat_prev_q   <= pat;
         side_q       <= side_d;
         state_q      <= state_d;
         hold_q       <= hold_d;
         mode_q       <= mode_d;
         mode_valid_q <= (mode_d != mode_q);
         lost_q       <= (state_d != TRACK);
      end
   end

   assign mode       = mode_q;
   assign mode_valid = mode_valid_q;
   assign lost       = lost_q;

endmodule

// File: tb/tb_line_tracker_filter.sv
// Self-checking bench for line_tracker_filter: directed table, corner sequences and
// randomized stimulus compared against a history-based behavioural model.
module tb_line_tracker_filter;

   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int HOLD   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       l = 1'b1, m = 1'b1, r = 1'b1;
   logic [2:0] mode;
   logic       mode_valid, lost;

   line_tracker_filter #(
      .SYNC_STAGES     (SYNC),
      .STABLE_CYCLES   (STABLE),
      .LOST_HOLD_CYCLES(HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .left_signal (l),
      .mid_signal  (m),
      .right_signal(r),
      .mode        (mode),
      .mode_valid  (mode_valid),
      .lost        (lost)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: raw samples per edge since reset, committed pattern, last command etc.
   logic [2:0] hist[$];
   logic [2:0] stable_m, pat_prev_m, side_code_m, exp_mode;
   logic       exp_valid, exp_lost;
   int         lost_since;

   typedef struct {
      logic [2:0] in;
      int         cycles;
      logic [2:0] exp_mode;
      logic       exp_lost;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] raw_at(input int idx);
      if (idx < 0) return 3'b111;
      return hist[idx];
   endfunction

   task automatic model_reset();
      hist.delete();
      stable_m    = 3'b111;
      pat_prev_m  = 3'b111;
      side_code_m = 3'b000;
      exp_mode    = 3'b111;
      exp_valid   = 1'b0;
      exp_lost    = 1'b0;
      lost_since  = -1;
   endtask

   // One rising edge: the sensor value v is what the first synchroniser stage captures.
   task automatic model_edge(input logic [2:0] v);
      int         t;
      logic [2:0] pat, nxt, ref_v;
      bit         run_ok;
      hist.push_back(v);
      t = hist.size() - 1;
      pat = (stable_m == 3'b010) ? 3'b111 : (stable_m == 3'b101) ? pat_prev_m : stable_m;
      if (pat != 3'b000) begin
         nxt        = pat;
         lost_since = -1;
      end else begin
         if (lost_since < 0) lost_since = t;
         nxt = ((t - lost_since) >= HOLD) ? 3'b010 : side_code_m;
      end
      exp_valid = (nxt != exp_mode);
      exp_mode  = nxt;
      exp_lost  = (lost_since >= 0);
      if (pat != pat_prev_m) begin
         if (pat == 3'b110 || pat == 3'b100)      side_code_m = 3'b100;
         else if (pat == 3'b011 || pat == 3'b001) side_code_m = 3'b001;
         else if (pat == 3'b111)                  side_code_m = 3'b000;
      end
      pat_prev_m = pat;
      // Commit when a new synchronised value appeared STABLE edges ago and held for the
      // STABLE-1 edges after it (the current edge's sample does not matter).
      ref_v  = raw_at(t - SYNC - STABLE);
      run_ok = (ref_v != raw_at(t - SYNC - STABLE - 1)) && (ref_v != stable_m);
      for (int j = 1; j < STABLE; j++)
         if (raw_at(t - SYNC - j) != ref_v) run_ok = 1'b0;
      if (run_ok) stable_m = ref_v;
   endtask

   task automatic tick(input logic [2:0] v);
      {l, m, r} = v;
      @(posedge clk);
      model_edge(v);
      @(negedge clk);
      check("mode", mode, exp_mode);
      check("mode_valid", 3'(mode_valid), 3'(exp_valid));
      check("lost", 3'(lost), 3'(exp_lost));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mode", mode, 3'b111);
      check("rst_valid", 3'(mode_valid), 3'b000);
      check("rst_lost", 3'(lost), 3'b000);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_mode", mode, 3'b111);
   endtask

   initial begin
      bit         saw;
      logic [2:0] p;
      int         dur;

      tbl[0]  = '{3'b111, 12, 3'b111, 1'b0};
      tbl[1]  = '{3'b110, 12, 3'b110, 1'b0};
      tbl[2]  = '{3'b010, 12, 3'b111, 1'b0};
      tbl[3]  = '{3'b100, 12, 3'b100, 1'b0};
      tbl[4]  = '{3'b101, 12, 3'b100, 1'b0};
      tbl[5]  = '{3'b000, 10, 3'b100, 1'b1};
      tbl[6]  = '{3'b000, 10, 3'b010, 1'b1};
      tbl[7]  = '{3'b001, 12, 3'b001, 1'b0};
      tbl[8]  = '{3'b000, 12, 3'b001, 1'b1};
      tbl[9]  = '{3'b011, 12, 3'b011, 1'b0};
      tbl[10] = '{3'b111, 12, 3'b111, 1'b0};
      tbl[11] = '{3'b000, 12, 3'b000, 1'b1};
      tbl[12] = '{3'b010, 12, 3'b111, 1'b0};

      do_reset();

      for (int i = 0; i < 13; i++) begin
         repeat (tbl[i].cycles) tick(tbl[i].in);
         check($sformatf("tbl%0d_mode", i), mode, tbl[i].exp_mode);
         check($sformatf("tbl%0d_lost", i), 3'(lost), 3'(tbl[i].exp_lost));
      end

      // Step latency: new code visible after the 8th edge, single valid pulse.
      repeat (12) tick(3'b111);
      for (int i = 0; i < 9; i++) begin
         tick(3'b110);
         check("latency_mode", mode, (i < 7) ? 3'b111 : 3'b110);
         check("latency_valid", 3'(mode_valid), (i == 7) ? 3'b001 : 3'b000);
      end

      // Three-cycle dropout while centred must be filtered out.
      repeat (12) tick(3'b111);
      for (int i = 0; i < 13; i++) begin
         tick((i < 3) ? 3'b000 : 3'b111);
         check("glitch_mode", mode, 3'b111);
         check("glitch_valid", 3'(mode_valid), 3'b000);
      end

      // Four-cycle dropout commits on the same edge the mismatch returns.
      saw = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick((i < 4) ? 3'b000 : 3'b111);
         if (mode == 3'b000) saw = 1'b1;
      end
      check("commit_wins_seen", 3'(saw), 3'b001);
      check("commit_wins_final", mode, 3'b111);

      // Reset while searching, then a full debounce is needed again.
      repeat (18) tick(3'b000);
      check("search_mode", mode, 3'b010);
      check("search_lost", 3'(lost), 3'b001);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick(3'b000);
         check("post_rst_mode", mode, (i < 7) ? 3'b111 : 3'b000);
         check("post_rst_lost", 3'(lost), (i < 7) ? 3'b000 : 3'b001);
      end

      // Randomized segments with occasional resets.
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         p   = 3'($urandom_range(0, 7));
         dur = int'($urandom_range(1, 12));
         if ($urandom_range(0, 3) == 0) begin
            p   = 3'b000;
            dur = int'($urandom_range(1, 22));
         end
         repeat (dur) tick(p);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
